// File: rtl/dma_controller_if.sv
// Bus and register-window signals between the DMA engine, the CPU register port and the external bus.
// The master side is the DMA engine; the slave side is the CPU/bus environment.
interface dma_controller_if;
   logic        cfg_wr;
   logic [2:0]  cfg_addr;
   logic [7:0]  cfg_wdata;
   logic [7:0]  cfg_rdata;
   logic        dma_req;
   logic        dma_ack;
   logic        pin_wait;
   logic [7:0]  data_bus_in;
   logic [21:0] address_bus;
   logic [7:0]  data_bus_out;
   logic        rd;
   logic        wr;
   logic        mem_io;
   logic        bus_en;
   logic        done_irq;
   logic        busy;

   modport master (
      input  cfg_wr, cfg_addr, cfg_wdata, dma_ack, pin_wait, data_bus_in,
      output cfg_rdata, dma_req, address_bus, data_bus_out, rd, wr, mem_io,
             bus_en, done_irq, busy
   );

   modport slave (
      output cfg_wr, cfg_addr, cfg_wdata, dma_ack, pin_wait, data_bus_in,
      input  cfg_rdata, dma_req, address_bus, data_bus_out, rd, wr, mem_io,
             bus_en, done_irq, busy
   );
endinterface

// File: rtl/dma_controller.sv
// Single-channel 8-bit DMA engine: borrows the CPU bus via dma_req/dma_ack, copies cnt bytes
// from src to dst, yields the bus every BURST_LEN transfers and pulses done_irq on completion.
module dma_controller #(
   parameter int unsigned BURST_LEN = 16
) (
   input  logic             clk,
   input  logic             arst,
   dma_controller_if.master bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_READ, S_WRITE, S_RELEASE, S_DONE
   } state_t;

   localparam logic [7:0] LP_BURST = 8'(BURST_LEN);

   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_src;
   logic [15:0] r_dst;
   logic [15:0] r_cnt;
   logic        r_src_io;
   logic        r_dst_io;
   logic        r_src_inc;
   logic        r_dst_inc;
   logic        r_done;
   logic        r_err;
   logic [7:0]  r_buf;
   logic [7:0]  r_burst;

   logic        w_busy;
   logic        w_ctrl_wr;
   logic        w_abort;
   logic        w_start;
   logic        w_ack_lost;
   logic        w_rd_done;
   logic        w_xfer_done;
   logic [15:0] w_cnt_dec;
   logic [7:0]  w_burst_inc;

   assign w_busy      = (r_state == S_REQ) || (r_state == S_READ) ||
                        (r_state == S_WRITE) || (r_state == S_RELEASE);
   assign w_ctrl_wr   = bus.cfg_wr && (bus.cfg_addr == 3'd6);
   assign w_abort     = w_ctrl_wr && bus.cfg_wdata[7];
   assign w_start     = w_ctrl_wr && bus.cfg_wdata[0] && !bus.cfg_wdata[7];
   assign w_ack_lost  = ((r_state == S_READ) || (r_state == S_WRITE)) && !bus.dma_ack;
   assign w_rd_done   = (r_state == S_READ) && bus.dma_ack && !bus.pin_wait && !w_abort;
   assign w_xfer_done = (r_state == S_WRITE) && bus.dma_ack && !bus.pin_wait && !w_abort;
   assign w_cnt_dec   = r_cnt - 16'd1;
   assign w_burst_inc = r_burst + 8'd1;

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Abort beats everything; losing the grant abandons the cycle in flight.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (w_start) w_next = (r_cnt != 16'd0) ? S_REQ : S_DONE;
         S_REQ:     if (w_abort) w_next = S_IDLE;
                    else if (bus.dma_ack) w_next = S_READ;
         S_READ:    if (w_abort || !bus.dma_ack) w_next = S_IDLE;
                    else if (!bus.pin_wait) w_next = S_WRITE;
         S_WRITE:   if (w_abort || !bus.dma_ack) w_next = S_IDLE;
                    else if (!bus.pin_wait) begin
                       if (w_cnt_dec == 16'd0)          w_next = S_DONE;
                       else if (w_burst_inc == LP_BURST) w_next = S_RELEASE;
                       else                              w_next = S_READ;
                    end
         S_RELEASE: if (w_abort) w_next = S_IDLE;
                    else if (!bus.dma_ack) w_next = S_REQ;
         S_DONE:    w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         r_src     <= '0;
         r_dst     <= '0;
         r_cnt     <= '0;
         r_src_io  <= 1'b0;
         r_dst_io  <= 1'b0;
         r_src_inc <= 1'b0;
         r_dst_inc <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_buf     <= '0;
         r_burst   <= '0;
      end else begin
         if (bus.cfg_wr && !w_busy) begin
            case (bus.cfg_addr)
               3'd0: r_src[7:0]  <= bus.cfg_wdata;
               3'd1: r_src[15:8] <= bus.cfg_wdata;
               3'd2: r_dst[7:0]  <= bus.cfg_wdata;
               3'd3: r_dst[15:8] <= bus.cfg_wdata;
               3'd4: r_cnt[7:0]  <= bus.cfg_wdata;
               3'd5: r_cnt[15:8] <= bus.cfg_wdata;
               3'd6: begin
                  r_src_io  <= bus.cfg_wdata[1];
                  r_dst_io  <= bus.cfg_wdata[2];
                  r_src_inc <= bus.cfg_wdata[3];
                  r_dst_inc <= bus.cfg_wdata[4];
                  r_done    <= 1'b0;
                  r_err     <= 1'b0;
               end
               default: ;
            endcase
         end
         if ((r_state == S_REQ) && bus.dma_ack && !w_abort) r_burst <= '0;
         if (w_rd_done) r_buf <= bus.data_bus_in;
         if (w_xfer_done) begin
            r_cnt   <= w_cnt_dec;
            r_src   <= r_src + {15'd0, r_src_inc};
            r_dst   <= r_dst + {15'd0, r_dst_inc};
            r_burst <= w_burst_inc;
         end
         if (r_state == S_DONE) r_done <= 1'b1;
         if (w_ack_lost && !w_abort) r_err <= 1'b1;
      end
   end

   // Bus outputs decode straight from registered state, so they only move on clock edges or reset.
   always_comb begin
      bus.dma_req      = (r_state == S_REQ) || (r_state == S_READ) || (r_state == S_WRITE);
      bus.bus_en       = (r_state == S_READ) || (r_state == S_WRITE);
      bus.rd           = (r_state != S_READ);
      bus.wr           = (r_state != S_WRITE);
      bus.mem_io       = 1'b1;
      bus.address_bus  = '0;
      bus.data_bus_out = r_buf;
      bus.done_irq     = (r_state == S_DONE);
      bus.busy         = w_busy;
      if (r_state == S_READ) begin
         bus.mem_io      = ~r_src_io;
         bus.address_bus = {6'b0, r_src};
      end else if (r_state == S_WRITE) begin
         bus.mem_io      = ~r_dst_io;
         bus.address_bus = {6'b0, r_dst};
      end
   end

   always_comb begin
      bus.cfg_rdata = '0;
      case (bus.cfg_addr)
         3'd0: bus.cfg_rdata = r_src[7:0];
         3'd1: bus.cfg_rdata = r_src[15:8];
         3'd2: bus.cfg_rdata = r_dst[7:0];
         3'd3: bus.cfg_rdata = r_dst[15:8];
         3'd4: bus.cfg_rdata = r_cnt[7:0];
         3'd5: bus.cfg_rdata = r_cnt[15:8];
         3'd6: bus.cfg_rdata = {3'b0, r_dst_inc, r_src_inc, r_dst_io, r_src_io, 1'b0};
         3'd7: bus.cfg_rdata = {5'b0, r_err, r_done, w_busy};
         default: bus.cfg_rdata = '0;
      endcase
   end
endmodule

// File: doc/dma_controller.md
Name: dma_controller

Overview:
- Single-channel 8-bit DMA engine that borrows the external memory/IO bus from the CPU core through its dma_req/dma_ack handshake.
- Performs block copies memory/IO -> memory/IO and is programmed by the CPU through a small register window.
- Hands the bus back every BURST_LEN transfers so the CPU is not starved.
- Raises a one-cycle completion pulse intended for one of the CPU's pins_irq_req lines.

Parameters:
BURST_LEN, 16, transfers per bus tenure before forced release (1..255)

Ports:
clk  in  1  system clock
arst  in  1  asynchronous reset, active-low
cfg_wr  in  1  register write strobe, active-high, one cycle
cfg_addr  in  3  register select: 0 srcl, 1 srch, 2 dstl, 3 dsth, 4 cntl, 5 cnth, 6 ctrl, 7 status (read-only)
cfg_wdata  in  8  register write data
cfg_rdata  out  8  combinational readback of the register selected by cfg_addr
dma_req  out  1  bus request to the CPU
dma_ack  in  1  bus grant from the CPU
pin_wait  in  1  bus wait, active-high; stretches the current rd/wr cycle
data_bus_in  in  8  bus read data
address_bus  out  22  {6'b0, addr16} while owning the bus, else 0
data_bus_out  out  8  write data (buffer)
rd  out  1  read strobe, active-low
wr  out  1  write strobe, active-low
mem_io  out  1  1 = memory space, 0 = IO space
bus_en  out  1  high while this block drives address/rd/wr/mem_io/data
done_irq  out  1  one-cycle completion pulse
busy  out  1  transfer in progress

Behaviour:
- Reset values:
  - all registers 0; state IDLE
  - dma_req = 0, bus_en = 0, rd = 1, wr = 1, mem_io = 1
  - address_bus = 0, data_bus_out = 0, done_irq = 0, busy = 0
- ctrl bits:
  - [0] start (write-1 pulse, self-clearing)
  - [1] src_io
  - [2] dst_io
  - [3] src_inc
  - [4] dst_inc
  - [7] abort (write-1 pulse)
- status register: [0] busy, [1] done (sticky, cleared by a ctrl write), [2] err (sticky, cleared by a ctrl write).
- While busy, writes to addresses 0-5 are ignored. A ctrl write while busy only honours abort.
- States: IDLE, REQ, READ, WRITE, RELEASE, DONE.
- IDLE:
  - start with cnt != 0 -> REQ, busy = 1.
  - start with cnt == 0 -> DONE directly, no bus request.
- REQ: dma_req = 1. On dma_ack = 1 -> READ, bus_en = 1, burst counter cleared.
- READ:
  - Drives address = src, mem_io = ~src_io, rd = 0.
  - On a cycle with pin_wait = 0, latch data_bus_in into the buffer at that clock edge -> WRITE.
  - While pin_wait = 1, remain in READ with outputs stable.
- WRITE:
  - Drives address = dst, mem_io = ~dst_io, data_bus_out = buffer, wr = 0.
  - On pin_wait = 0, perform all of the following on the same edge:
    - cnt <= cnt - 1
    - src <= src + src_inc
    - dst <= dst + dst_inc (16-bit wrap FFFF -> 0000)
    - burst counter + 1
  - Then:
    - new cnt == 0 -> DONE
    - else burst counter == BURST_LEN -> RELEASE
    - else -> READ
  - Each transfer therefore takes 2 clocks minimum.
- RELEASE: dma_req = 0, bus_en = 0, strobes high. Waits for dma_ack = 0, then -> REQ.
- DONE:
  - One cycle: done_irq = 1, sets status.done, dma_req = 0, bus_en = 0, busy = 0 -> IDLE.
  - cnt reads 0; src/dst hold their final incremented values.
- dma_ack falling while in READ or WRITE:
  - Abandon the cycle immediately (strobes high next edge), set err, go to IDLE.
  - No done_irq; cnt/src/dst keep their values at the last completed transfer.
- abort while busy: same as the ack-loss case but does not set err. dma_req drops next edge.
- start and abort in the same write: abort wins; no transfer begins.
- cnt = 0xFFFF: full 65535 transfers. cnt == 0 never means 65536.
- Strobes rd/wr change only on the clock edge; never both low simultaneously.
- Asynchronous reset mid-transfer: all outputs return to reset values immediately.

Test Plan:
- src = 0x1000, dst = 0x2000, cnt = 3, ctrl = 0x19 (start, src_inc, dst_inc); dma_ack follows dma_req after 2 cycles -> reads 1000/1001/1002, writes 2000/2001/2002, mem_io = 1, one done_irq pulse, cnt = 0, src = 0x1003, dst = 0x2003, 6 bus clocks.
- BURST_LEN = 16, cnt = 40 -> dma_req deasserts after transfers 16 and 32; restarts only after dma_ack is seen low; 40 writes total, single done_irq.
- pin_wait held high 3 cycles during the second READ -> rd stays low 4 cycles, data latched only on the pin_wait-low edge, address stable throughout.
- src_io = 1, src_inc = 0, dst_inc = 1, src = 0x0040, cnt = 4 -> four IO reads at 0x0040 with mem_io = 0, then memory writes with mem_io = 1; dst = 0xFFFE wraps through 0x0000.
- cnt = 0 with start -> no dma_req, done_irq next cycle. Abort written in the middle of a READ -> rd high next edge, busy = 0, err = 0. dma_ack dropped during a WRITE -> err = 1, no done_irq.
- arst asserted during a WRITE -> dma_req = 0, rd = wr = 1, bus_en = 0, all registers 0, immediately, without waiting for a clock edge.
